// File: rtl/intra_neighbour_fetch.sv
// -----------------------------------------------------------------------------
// intra_neighbour_fetch
//
// Reader side of the reconstructed-frame store used by the intra encoder loop.
// For each requested 4x4 (luma) or 8x8 (chroma) block it fetches the intra
// prediction neighbours of one plane and streams them one sample per
// handshake:
//   index 0          top-left      (row-1, col-1)
//   index 1..N       top row       (row-1, col+k-1)
//   index N+1..2N    left column   (row+k-N-1, col-1)
//   index 2N+1..3N   top-right     (row-1, col+N+k-1)   [INTRA_NB_TOPRIGHT_EN]
// Samples outside the frame are not read; they are presented as 128
// (top-right falls back to the last top sample when the top row exists).
//
// Optional feature macro: INTRA_NB_TOPRIGHT_EN (undefined by default, in which
// case no top-right logic is built and a block is 2N+1 samples).
//
// Parameters
//   WIDTH   frame width in samples, also the memory row stride
//   LENGTH  frame height in samples
//   AW      memory address width
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   req_valid/ready    block request handshake (ready only while idle)
//   req_row/col/size   block top-left position, size 0=4x4 1=8x8
//   mem_rd_en/addr     frame memory read strobe and address (row*WIDTH+col)
//   mem_rd_data        synchronous read data, valid the cycle after the strobe
//   nb_valid/ready     neighbour sample handshake
//   nb_data/index      sample value and its index within the block
//   nb_avail           1 = sample read from memory, 0 = substituted
//   nb_last            final sample of the block
//   err                one-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
module intra_neighbour_fetch #(
   parameter int WIDTH  = 32,
   parameter int LENGTH = 32,
   parameter int AW     = $clog2(WIDTH*LENGTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [15:0]   req_row,
   input  logic [15:0]   req_col,
   input  logic          req_size,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          nb_valid,
   input  logic          nb_ready,
   output logic [7:0]    nb_data,
   output logic [4:0]    nb_index,
   output logic          nb_avail,
   output logic          nb_last,
   output logic          err
);

   localparam int          AX      = AW + 1;
   localparam logic [AW:0] W_X     = AX'(WIDTH);
   localparam logic [AW:0] FRAME_X = AX'(WIDTH * LENGTH);
   localparam logic [AW:0] ONE_X   = AX'(1);
   localparam logic [16:0] W17     = 17'(WIDTH);
   localparam logic [16:0] L17     = 17'(LENGTH);
   localparam logic [7:0]  FILL    = 8'd128;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_NEXT    = 2'd1,
      S_WAIT    = 2'd2,
      S_PRESENT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [AW:0] row_q, row_d;
   logic [AW:0] col_q, col_d;
   logic        n8_q, n8_d;
   logic [4:0]  idx_q, idx_d;
   logic [7:0]  data_q, data_d;
   logic [4:0]  index_q, index_d;
   logic        avail_q, avail_d;
   logic        last_q, last_d;
   logic        err_q, err_d;
`ifdef INTRA_NB_TOPRIGHT_EN
   logic [7:0]  top_q, top_d;
   logic        tr_edge;
`endif

   // Sample decode for the current index
   logic [4:0]  n5, n2, last_idx;
   logic [AW:0] n_x, idx_x;
   logic        row_nz, col_nz;
   logic        s_avail;
   logic [AW:0] s_row, s_col, addr_x;
   logic [7:0]  s_fill;
   logic        s_rd;

   // A request is refused when misaligned to its block size or when the block
   // would extend past the bottom or right frame edge.
   function automatic logic req_bad_f(input logic [15:0] r,
                                      input logic [15:0] c,
                                      input logic        sz);
      logic [2:0]  mask;
      logic [16:0] n17;
      mask = sz ? 3'b111 : 3'b011;
      n17  = sz ? 17'd8 : 17'd4;
      return (|(r[2:0] & mask)) | (|(c[2:0] & mask)) |
             (({1'b0, r} + n17) > L17) | (({1'b0, c} + n17) > W17);
   endfunction

   assign n5       = n8_q ? 5'd8 : 5'd4;
   assign n2       = {n5[3:0], 1'b0};
`ifdef INTRA_NB_TOPRIGHT_EN
   assign last_idx = n2 + n5;
   // Top-right lies beyond the right frame edge.
   assign tr_edge  = (col_q + n_x) >= W_X;
`else
   assign last_idx = n2;
`endif
   assign n_x      = n8_q ? AX'(8) : AX'(4);
   assign idx_x    = AX'(idx_q);
   assign row_nz   = |row_q;
   assign col_nz   = |col_q;

   always_comb begin
      s_avail = 1'b0;
      s_row   = row_q - ONE_X;
      s_col   = col_q - ONE_X;
      s_fill  = FILL;
      if (idx_q == 5'd0) begin
         s_avail = row_nz & col_nz;
      end else if (idx_q <= n5) begin
         s_avail = row_nz;
         s_col   = col_q + idx_x - ONE_X;
      end else if (idx_q <= n2) begin
         s_avail = col_nz;
         s_row   = row_q + idx_x - n_x - ONE_X;
      end
`ifdef INTRA_NB_TOPRIGHT_EN
      else begin
         s_avail = row_nz & ~tr_edge;
         s_col   = col_q + idx_x - n_x - ONE_X;
         // Top-right replicates the last top sample when the top row exists.
         s_fill  = row_nz ? top_q : FILL;
      end
`endif
   end

   // Address formed one bit wider than the memory so a stray value can never
   // alias back into the frame; the strobe is also withheld outside it.
   assign addr_x    = s_row * W_X + s_col;
   assign s_rd      = (state_q == S_NEXT) & s_avail & (addr_x < FRAME_X);
   assign mem_rd_en = s_rd;
   assign mem_addr  = s_rd ? addr_x[AW-1:0] : '0;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      n8_d    = n8_q;
      idx_d   = idx_q;
      data_d  = data_q;
      index_d = index_q;
      avail_d = avail_q;
      last_d  = last_q;
      err_d   = 1'b0;
`ifdef INTRA_NB_TOPRIGHT_EN
      top_d   = top_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_bad_f(req_row, req_col, req_size)) begin
                  err_d = 1'b1;
               end else begin
                  row_d   = AX'(req_row);
                  col_d   = AX'(req_col);
                  n8_d    = req_size;
                  idx_d   = 5'd0;
                  state_d = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            index_d = idx_q;
            avail_d = s_avail;
            last_d  = (idx_q == last_idx);
            if (s_avail) begin
               state_d = S_WAIT;
            end else begin
               data_d  = s_fill;
               state_d = S_PRESENT;
            end
         end
         S_WAIT: begin
            data_d  = mem_rd_data;
`ifdef INTRA_NB_TOPRIGHT_EN
            if (idx_q == n5) top_d = mem_rd_data;
`endif
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (nb_ready) begin
               if (last_q) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = S_NEXT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         n8_q    <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         index_q <= '0;
         avail_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef INTRA_NB_TOPRIGHT_EN
         top_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         n8_q    <= n8_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         index_q <= index_d;
         avail_q <= avail_d;
         last_q  <= last_d;
         err_q   <= err_d;
`ifdef INTRA_NB_TOPRIGHT_EN
         top_q   <= top_d;
`endif
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign nb_valid  = (state_q == S_PRESENT);
   assign nb_data   = data_q;
   assign nb_index  = index_q;
   assign nb_avail  = avail_q;
   assign nb_last   = last_q;
   assign err       = err_q;

endmodule

// File: tb/tb_intra_neighbour_fetch.sv
module tb_intra_neighbour_fetch;

   localparam int WIDTH  = 32;
   localparam int LENGTH = 32;
   localparam int AW     = 10;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [15:0]   req_row;
   logic [15:0]   req_col;
   logic          req_size;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rd_data;
   logic          nb_valid;
   logic          nb_ready;
   logic [7:0]    nb_data;
   logic [4:0]    nb_index;
   logic          nb_avail;
   logic          nb_last;
   logic          err;

   intra_neighbour_fetch #(.WIDTH(WIDTH), .LENGTH(LENGTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_row(req_row), .req_col(req_col), .req_size(req_size),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_data(nb_data),
      .nb_index(nb_index), .nb_avail(nb_avail), .nb_last(nb_last), .err(err)
   );

   typedef struct {
      int         idx;
      logic [7:0] data;
      bit         avail;
      bit         last;
      int         addr;
   } samp_t;

   logic [7:0] mem [WIDTH*LENGTH];
   samp_t      exp_q[$];
   samp_t      pin[$];
   int         total = 0;
   int         bad = 0;
   int         rd_count = 0;
   bit         read_seen = 0;
   bit         err_ok = 0;
   bit         rnd_ready = 0;
   int         stall_idx = -1;
   int         stall_cnt = 0;
   bit         poke = 0;

   logic [7:0] lit_a [9] = '{8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h87, 8'hA7, 8'hC7, 8'hE7};
   logic [7:0] lit_l [4] = '{8'd7, 8'd39, 8'd71, 8'd103};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: neighbour list of one block straight from the position rules.
   task automatic build_block(input int r, input int c, input bit sz, output samp_t blk[$]);
      int n, tot, sr, sc;
      bit av;
      samp_t s;
      logic [7:0] topv;
      blk.delete();
      topv = 8'd128;
      n = sz ? 8 : 4;
      tot = 2 * n + 1;
`ifdef INTRA_NB_TOPRIGHT_EN
      tot = 3 * n + 1;
`endif
      for (int i = 0; i < tot; i++) begin
         if (i == 0) begin
            sr = r - 1; sc = c - 1; av = (r > 0) && (c > 0);
         end else if (i <= n) begin
            sr = r - 1; sc = c + i - 1; av = (r > 0);
         end else if (i <= 2 * n) begin
            sr = r + (i - n) - 1; sc = c - 1; av = (c > 0);
         end else begin
            sr = r - 1; sc = c + n + (i - 2 * n) - 1; av = (r > 0) && (c + n < WIDTH);
         end
         s.idx   = i;
         s.avail = av;
         s.last  = (i == tot - 1);
         s.addr  = av ? sr * WIDTH + sc : 0;
         if (av) s.data = mem[sr * WIDTH + sc];
         else if (i > 2 * n && r > 0) s.data = topv;
         else s.data = 8'd128;
         if (i == n) topv = s.data;
         blk.push_back(s);
      end
   endtask

   // nb_ready driver: optional 5-cycle stall on one index, else random or high.
   always @(posedge clk) begin
      #1;
      if (nb_valid && (int'(nb_index) == stall_idx) && stall_cnt < 5) begin
         nb_ready = 1'b0;
         stall_cnt++;
      end else begin
         nb_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Compare process: every cycle, outputs against the front of the model queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (!err_ok && err !== 1'b0) check("err_spurious", err, 1'b0);
         if (mem_rd_en) begin
            rd_count++;
            total++;
            if (exp_q.size() == 0 || !exp_q[0].avail || read_seen) begin
               bad++;
               $display("FAIL rd_strobe: unexpected read addr=%0d (t=%0t)", mem_addr, $time);
            end else begin
               check("rd_addr", mem_addr, exp_q[0].addr);
            end
            read_seen = 1;
         end
         if (nb_valid) begin
            if (exp_q.size() == 0) begin
               check("nb_valid_spurious", nb_valid, 1'b0);
            end else begin
               check("nb_index", nb_index, exp_q[0].idx);
               check("nb_data", nb_data, exp_q[0].data);
               check("nb_avail", nb_avail, exp_q[0].avail);
               check("nb_last", nb_last, exp_q[0].last);
               if (exp_q[0].avail) check("rd_before_present", read_seen, 1'b1);
               if (nb_ready) begin
                  void'(exp_q.pop_front());
                  read_seen = 0;
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 1'b1);
      check({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_nb_valid"}, nb_valid, 1'b0);
      check({tag, "_nb_data"}, nb_data, 0);
      check({tag, "_nb_index"}, nb_index, 0);
      check({tag, "_nb_avail"}, nb_avail, 1'b0);
      check({tag, "_nb_last"}, nb_last, 1'b0);
      check({tag, "_err"}, err, 1'b0);
   endtask

   task automatic wait_idle();
      int g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!req_ready && g < 200);
      check("idle_reached", req_ready, 1'b1);
   endtask

   task automatic run_block(input int r, input int c, input bit sz);
      int n, cnt, lat, guard, rd0;
      bit bad_req, poked;
      samp_t blk[$];
      n = sz ? 8 : 4;
      bad_req = (r % n != 0) || (c % n != 0) || (r + n > LENGTH) || (c + n > WIDTH);
      wait_idle();
      rd0 = rd_count;
      lat = 2;
      if (bad_req) begin
         err_ok = 1;
      end else begin
         build_block(r, c, sz, blk);
         lat = blk[0].avail ? 3 : 2;
         foreach (blk[i]) exp_q.push_back(blk[i]);
      end
      req_row = 16'(r); req_col = 16'(c); req_size = sz; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (bad_req) begin
         @(negedge clk);
         check("err_pulse", err, 1'b1);
         check("err_no_valid", nb_valid, 1'b0);
         check("err_ready", req_ready, 1'b1);
         @(negedge clk);
         check("err_one_cycle", err, 1'b0);
         check("err_no_valid2", nb_valid, 1'b0);
         check("err_no_read", rd_count, rd0);
         err_ok = 0;
      end else begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!nb_valid && cnt < 20);
         check("first_latency", cnt, lat);
         guard = 0;
         poked = 0;
         while (exp_q.size() != 0 && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (poke && !poked && stall_cnt == 2) begin
               check("busy_not_ready", req_ready, 1'b0);
               req_row = 16'd0; req_col = 16'd0; req_size = 1'b0; req_valid = 1'b1;
               @(negedge clk);
               req_valid = 1'b0;
               poked = 1;
            end
         end
         if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL block_drain: %0d samples left for r=%0d c=%0d", exp_q.size(), r, c);
            exp_q.delete();
            read_seen = 0;
         end
         @(negedge clk);
         check("ready_after_block", req_ready, 1'b1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, rd0, n, r, c;
      bit sz;
      reset = 1'b1; req_valid = 1'b0; req_row = '0; req_col = '0; req_size = 1'b0;
      nb_ready = 1'b1; mem_rd_data = '0;
      for (int a = 0; a < WIDTH * LENGTH; a++) mem[a] = 8'(a);
      #12 check_reset_outputs("reset");
      #5 reset = 1'b0;

      // Model pins against hand-computed values.
      build_block(4, 8, 1'b0, pin);
      for (int i = 0; i < 9; i++) check("pin_a_data", pin[i].data, lit_a[i]);
      check("pin_a_last", pin[8].last, 1'b1);
      build_block(0, 8, 1'b0, pin);
      for (int i = 0; i < 4; i++) check("pin_l_data", pin[5 + i].data, lit_l[i]);
      check("pin_t_data", pin[2].data, 8'd128);
      build_block(0, 0, 1'b1, pin);
      check("pin_b_last", pin[16].last, 1'b1);
      check("pin_b_data", pin[9].data, 8'd128);
`ifdef INTRA_NB_TOPRIGHT_EN
      build_block(4, 8, 1'b0, pin);
      for (int i = 0; i < 4; i++) check("pin_tr_data", pin[9 + i].data, 108 + i);
      build_block(4, 28, 1'b0, pin);
      check("pin_tr_len", pin.size(), 13);
      for (int i = 0; i < 4; i++) check("pin_tr_edge", pin[9 + i].data, 8'h7F);
      check("pin_tr_avail", pin[12].avail, 1'b0);
`endif

      // Directed blocks.
      run_block(4, 8, 1'b0);
      rd0 = rd_count;
      run_block(0, 0, 1'b1);
      check("corner_no_reads", rd_count, rd0);
      run_block(0, 8, 1'b0);
`ifdef INTRA_NB_TOPRIGHT_EN
      run_block(4, 28, 1'b0);
`endif

      // Stall on index 3, with an ignored request while busy.
      stall_cnt = 0; stall_idx = 3; poke = 1;
      run_block(4, 8, 1'b0);
      check("stall_cycles", stall_cnt, 5);
      stall_idx = -1; poke = 0;

      // Rejected requests.
      run_block(30, 0, 1'b0);
      run_block(2, 0, 1'b0);
      run_block(32, 0, 1'b0);
      run_block(0, 28, 1'b1);

      // Reset in the middle of a block.
      wait_idle();
      build_block(4, 8, 1'b0, pin);
      foreach (pin[i]) exp_q.push_back(pin[i]);
      req_row = 16'd4; req_col = 16'd8; req_size = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      g = 0;
      while (!(nb_valid && nb_index == 5'd4) && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("reached_index4", nb_index, 5'd4);
      #2 reset = 1'b1;
      #1 check_reset_outputs("mid_reset");
      exp_q.delete();
      read_seen = 0;
      @(posedge clk);
      #3 reset = 1'b0;
      run_block(4, 8, 1'b0);

      // Randomized phase.
      for (int a = 0; a < WIDTH * LENGTH; a++) mem[a] = 8'($urandom);
      rnd_ready = 1;
      for (int t = 0; t < 50; t++) begin
         sz = 1'($urandom_range(0, 1));
         n = sz ? 8 : 4;
         if ($urandom_range(0, 5) == 0) begin
            r = $urandom_range(0, 40);
            c = $urandom_range(0, 40);
         end else begin
            r = $urandom_range(0, LENGTH / n - 1) * n;
            c = $urandom_range(0, WIDTH / n - 1) * n;
         end
         run_block(r, c, sz);
      end
      rnd_ready = 0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/intra_neighbour_fetch.md
Name: intra_neighbour_fetch

Overview:
- Reader side of the reconstructed-frame store that the intra encoder loop writes.
- For each requested 4x4 luma or 8x8 chroma block position, fetches the intra-prediction neighbours from frame memory: top-left, top row and left column.
- Streams the neighbours one sample per handshake to the prediction engine, substituting 128 for samples outside the frame.
- One instance serves one plane.

Parameters:
- WIDTH, 32, frame width in samples; also the row stride of the memory address.
- LENGTH, 32, frame height in samples.
- AW, $clog2(WIDTH*LENGTH), memory address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  block request valid.
- req_ready  out  1  high only in IDLE.
- req_row  in  16  block top row.
- req_col  in  16  block left column.
- req_size  in  1  0 = 4x4 (N=4), 1 = 8x8 (N=8).
- mem_rd_en  out  1  frame memory read strobe.
- mem_addr  out  AW  (row*WIDTH)+col.
- mem_rd_data  in  8  synchronous read data, valid the cycle after mem_rd_en.
- nb_valid  out  1  neighbour sample valid.
- nb_ready  in  1  consumer accepts the sample.
- nb_data  out  8  sample value.
- nb_index  out  5  sample index.
- nb_avail  out  1  1 = read from memory, 0 = substituted.
- nb_last  out  1  final sample of the block.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. req_ready=1. mem_rd_en, nb_valid, nb_last, err, nb_avail = 0. nb_data, nb_index, mem_addr = 0. Any in-flight block is dropped.
- Sample order, with sample i computed for index i:
  - index 0: top-left at (row-1, col-1).
  - indices 1..N: top at (row-1, col+k-1), k=1..N.
  - indices N+1..2N: left at (row+k-N-1, col-1).
  - Total 2N+1 samples.
- Availability:
  - Top and top-left are unavailable when row==0.
  - Left and top-left are unavailable when col==0.
  - An unavailable sample is presented as 128 with nb_avail=0, and no memory read is issued for it.
- Request acceptance: req_valid & req_ready at a clock edge.
- Request rejection: the request is rejected when any of these holds:
  - row or col is not a multiple of N;
  - row+N > LENGTH;
  - col+N > WIDTH.
  On rejection, err pulses high in the next cycle, no samples are produced, and the FSM stays in IDLE.
- FSM:
  - IDLE: on accept, latch row, col, N, and go to NEXT with idx=0.
  - NEXT: if sample idx is available, assert mem_rd_en with its address for exactly one cycle and go to WAIT. Otherwise load 128 into the output register and go to PRESENT.
  - WAIT: register mem_rd_data into nb_data, go to PRESENT.
  - PRESENT: nb_valid=1; nb_data, nb_index, nb_avail, nb_last held stable until nb_ready. On handshake: if nb_last, go to IDLE; else idx+1 and go to NEXT.
- Latency from accept edge to first nb_valid:
  - 3 cycles for an available sample (NEXT, WAIT, then PRESENT).
  - 2 cycles for a substituted sample.
- nb_last=1 only at idx=2N, or 3N with the optional feature.
- Address arithmetic is done at AW+1 bits, with no wrap; legal requests never form an out-of-range address.
- req_valid while busy is ignored (req_ready=0).
- nb_ready while nb_valid=0 has no effect.
- mem_rd_en never asserts outside NEXT.

Optional Feature:
- Macro INTRA_NB_TOPRIGHT_EN.
- Defined:
  - N extra top-right samples, indices 2N+1..3N, at (row-1, col+N+k-1).
  - Unavailable when row==0 or col+N >= WIDTH. In that case each sample equals the last top sample (index N) value, with nb_avail=0 and no read; if the top row is also unavailable, the value is 128.
  - Block total is 3N+1 samples.
- Undefined: 2N+1 samples, and no top-right logic is generated.

Test Plan:
- Memory preloaded with mem[a] = a & 0xFF, WIDTH=LENGTH=32. Request row=4, col=8, 4x4 -> 9 samples:
  - data 0x67, 0x68, 0x69, 0x6A, 0x6B, 0x87, 0xA7, 0xC7, 0xE7;
  - all nb_avail=1; nb_last on index 8;
  - first nb_valid 3 cycles after accept.
- Request row=0, col=0, 8x8 -> 17 samples, all 128 with nb_avail=0; mem_rd_en never high; nb_last at index 16.
- Request row=0, col=8, 4x4 -> indices 0..4 = 128 with avail=0; left samples = 7, 39, 71, 103 with avail=1.
- nb_ready held low for 5 cycles while index 3 is presented -> nb_data and nb_index stable, no mem_rd_en, then the sequence resumes at index 4.
- Request row=30, col=0, 4x4, and separately row=2, col=0, 4x4 -> err pulses 1 cycle, no nb_valid, req_ready stays 1. Reset asserted mid-block at index 4 -> all outputs 0 immediately; the next request completes normally.
- With INTRA_NB_TOPRIGHT_EN defined:
  - row=4, col=8, 4x4 -> indices 9..12 = 108..111, avail=1.
  - row=4, col=28, 4x4 -> indices 9..12 = 127 (0x7F), avail=0; 13 samples total.
